// File: rtl/lcd_pkg.sv
// Shared constants, state types and byte helpers for the HD44780 line writer.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_DDRAM    = 8'h80;
  localparam logic [7:0] LCD_ROW1_OFS = 8'h40;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_ADDR,
    ST_CHAR
  } topState_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_PULSE,
    PH_WAIT
  } bytePhase_e;

  function automatic logic [7:0] initCmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = LCD_FUNC_SET;
      2'd1:    cmd = LCD_DISP_ON;
      2'd2:    cmd = LCD_ENTRY;
      default: cmd = LCD_CLEAR;
    endcase
    return cmd;
  endfunction

  // Column 0 lives in the top byte, so column idx starts at bit 8*(15-idx).
  function automatic logic [7:0] charAt(input logic [127:0] line, input logic [3:0] idx);
    return line[{~idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Writes one byte to the LCD bus: SETUP with E low, E pulse, then the settle wait.
module lcd_byte_writer import lcd_pkg::*; #(
  parameter int SETUP_CYC      = 4,
  parameter int E_PULSE_CYC    = 25,
  parameter int WAIT_CYC       = 2500,
  parameter int CLEAR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  input  logic       long_wait_i,
  output logic       done_o,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic [7:0] lcd_data_o
);

  localparam int MAX_A   = (SETUP_CYC > E_PULSE_CYC) ? SETUP_CYC : E_PULSE_CYC;
  localparam int MAX_B   = (WAIT_CYC > CLEAR_WAIT_CYC) ? WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  bytePhase_e       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             long_q, long_d;
  logic             cntLast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      long_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      long_q  <= long_d;
    end
  end

  assign cntLast = (cnt_q == '0);

  // A start in the last WAIT cycle chains straight into the next SETUP with no gap.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    rs_d    = rs_q;
    data_d  = data_q;
    long_d  = long_q;
    done_o  = 1'b0;

    case (phase_q)
      PH_SETUP: begin
        if (cntLast) begin
          phase_d = PH_PULSE;
          cnt_d   = CNT_W'(E_PULSE_CYC - 1);
          e_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PH_PULSE: begin
        if (cntLast) begin
          phase_d = PH_WAIT;
          cnt_d   = long_q ? CNT_W'(CLEAR_WAIT_CYC - 1) : CNT_W'(WAIT_CYC - 1);
          e_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PH_WAIT: begin
        if (cntLast) begin
          phase_d = PH_IDLE;
          done_o  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase

    if (start_i) begin
      phase_d = PH_SETUP;
      cnt_d   = CNT_W'(SETUP_CYC - 1);
      e_d     = 1'b0;
      rs_d    = rs_i;
      data_d  = data_i;
      long_d  = long_wait_i;
    end
  end

  assign lcd_e_o    = e_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_data_o = data_q;

endmodule

// File: rtl/lcd_line_writer.sv
// Power-up/init sequencer for a 16x2 HD44780 LCD that then writes whole 16-char lines on request.
module lcd_line_writer import lcd_pkg::*; #(
  parameter int POWERUP_CYC    = 750000,
  parameter int SETUP_CYC      = 4,
  parameter int E_PULSE_CYC    = 25,
  parameter int WAIT_CYC       = 2500,
  parameter int CLEAR_WAIT_CYC = 100000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic         line_sel,
  input  logic [127:0] line_data,
  output logic         ack,
  output logic         busy,
  output logic         done,
  output logic         init_done,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_e,
  output logic [7:0]   lcd_data
);

  localparam int PWR_W = $clog2(POWERUP_CYC + 1);

  topState_e      state_q, state_d;
  logic [PWR_W-1:0] pwrCnt_q, pwrCnt_d;
  logic [1:0]     initIdx_q, initIdx_d;
  logic [3:0]     charIdx_q, charIdx_d;
  logic [127:0]   line_q, line_d;
  logic           ack_q, ack_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           initDone_q, initDone_d;

  logic           bwStart;
  logic           bwRs;
  logic [7:0]     bwData;
  logic           bwLong;
  logic           byteDone;

  lcd_byte_writer #(
    .SETUP_CYC      (SETUP_CYC),
    .E_PULSE_CYC    (E_PULSE_CYC),
    .WAIT_CYC       (WAIT_CYC),
    .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
  ) u_byte (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (bwStart),
    .rs_i        (bwRs),
    .data_i      (bwData),
    .long_wait_i (bwLong),
    .done_o      (byteDone),
    .lcd_e_o     (lcd_e),
    .lcd_rs_o    (lcd_rs),
    .lcd_data_o  (lcd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_PWRUP;
      pwrCnt_q   <= '0;
      initIdx_q  <= '0;
      charIdx_q  <= '0;
      line_q     <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      initDone_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwrCnt_q   <= pwrCnt_d;
      initIdx_q  <= initIdx_d;
      charIdx_q  <= charIdx_d;
      line_q     <= line_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      initDone_q <= initDone_d;
    end
  end

  // Each state launches its next byte on the edge the previous byte's wait ends.
  always_comb begin
    state_d    = state_q;
    pwrCnt_d   = pwrCnt_q;
    initIdx_d  = initIdx_q;
    charIdx_d  = charIdx_q;
    line_d     = line_q;
    ack_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    initDone_d = initDone_q;
    bwStart    = 1'b0;
    bwRs       = 1'b0;
    bwData     = 8'h00;
    bwLong     = 1'b0;

    case (state_q)
      ST_PWRUP: begin
        if (pwrCnt_q == PWR_W'(POWERUP_CYC - 1)) begin
          state_d   = ST_INIT;
          initIdx_d = 2'd0;
          bwStart   = 1'b1;
          bwData    = initCmd(2'd0);
        end else begin
          pwrCnt_d = pwrCnt_q + 1'b1;
        end
      end
      ST_INIT: begin
        if (byteDone) begin
          if (initIdx_q == 2'd3) begin
            state_d    = ST_IDLE;
            initDone_d = 1'b1;
          end else begin
            initIdx_d = initIdx_q + 2'd1;
            bwStart   = 1'b1;
            bwData    = initCmd(initIdx_q + 2'd1);
            bwLong    = (initIdx_q == 2'd2);
          end
        end
      end
      ST_IDLE: begin
        // The address byte itself is captured by the byte writer, which holds the row choice.
        if (initDone_q && req) begin
          state_d = ST_ADDR;
          line_d  = line_data;
          ack_d   = 1'b1;
          busy_d  = 1'b1;
          bwStart = 1'b1;
          bwData  = LCD_DDRAM | (line_sel ? LCD_ROW1_OFS : 8'h00);
        end
      end
      ST_ADDR: begin
        if (byteDone) begin
          state_d   = ST_CHAR;
          charIdx_d = 4'd0;
          bwStart   = 1'b1;
          bwRs      = 1'b1;
          bwData    = charAt(line_q, 4'd0);
        end
      end
      ST_CHAR: begin
        if (byteDone) begin
          if (charIdx_q == 4'd15) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            charIdx_d = charIdx_q + 4'd1;
            bwStart   = 1'b1;
            bwRs      = 1'b1;
            bwData    = charAt(line_q, charIdx_q + 4'd1);
          end
        end
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign init_done = initDone_q;
  assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_line_writer.sv
// Self-checking bench for lcd_line_writer: init sequence, line writes, handshake and reset corners.
module tb_lcd_line_writer;

  localparam int S  = 2;
  localparam int P  = 3;
  localparam int W  = 4;
  localparam int CW = 10;
  localparam int PU = 20;
  localparam int T  = S + P + W;
  localparam int TC = S + P + CW;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req = 1'b0;
  logic         line_sel = 1'b0;
  logic [127:0] line_data = '0;
  logic         ack, busy, done, init_done;
  logic         lcd_rs, lcd_rw, lcd_e;
  logic [7:0]   lcd_data;

  always #5 clk = ~clk;

  lcd_line_writer #(
    .POWERUP_CYC    (PU),
    .SETUP_CYC      (S),
    .E_PULSE_CYC    (P),
    .WAIT_CYC       (W),
    .CLEAR_WAIT_CYC (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .line_sel  (line_sel),
    .line_data (line_data),
    .ack       (ack),
    .busy      (busy),
    .done      (done),
    .init_done (init_done),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_data  (lcd_data)
  );

  typedef struct {
    logic         sel;
    logic [127:0] data;
    logic [7:0]   expAddr;
  } vec_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         cycle;
  } pulse_t;

  int         compared = 0;
  int         mismatched = 0;
  int         cyc = 0;
  int         initDoneCyc = -1;
  pulse_t     pulses[$];
  vec_t       vecs[$];
  logic       prevE = 1'b0;
  logic       prevRs = 1'b0;
  logic [7:0] prevData = 8'h00;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  // One clock: records E rising edges and checks the bus is frozen while E is high or just fell.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (rst_n) begin
      if (prevE) begin
        compared++;
        if (lcd_data !== prevData || lcd_rs !== prevRs) begin
          mismatched++;
          $display("[TB] FAIL bus_stable cyc=%0d: got rs=%0b data=%02h, required rs=%0b data=%02h",
                   cyc, lcd_rs, lcd_data, prevRs, prevData);
        end
      end
      if (lcd_e && !prevE) pulses.push_back('{lcd_rs, lcd_data, cyc});
      if (init_done && initDoneCyc < 0) initDoneCyc = cyc;
    end
    prevE    = lcd_e;
    prevRs   = lcd_rs;
    prevData = lcd_data;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ack"},       64'(ack), 64'd0);
    checkOutput({tag, "_busy"},      64'(busy), 64'd0);
    checkOutput({tag, "_done"},      64'(done), 64'd0);
    checkOutput({tag, "_init_done"}, 64'(init_done), 64'd0);
    checkOutput({tag, "_lcd_rs"},    64'(lcd_rs), 64'd0);
    checkOutput({tag, "_lcd_rw"},    64'(lcd_rw), 64'd0);
    checkOutput({tag, "_lcd_e"},     64'(lcd_e), 64'd0);
    checkOutput({tag, "_lcd_data"},  64'(lcd_data), 64'd0);
  endtask

  // Releases reset and expects exactly the four init commands, then init_done; req may already be high.
  task automatic initSequence();
    logic [7:0] expCmd[4];
    int acks = 0;
    expCmd[0] = 8'h38; expCmd[1] = 8'h0C; expCmd[2] = 8'h06; expCmd[3] = 8'h01;
    pulses.delete();
    initDoneCyc = -1;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 300 && initDoneCyc < 0; i++) begin
      tick();
      if (ack) acks++;
    end
    checkOutput("init_done_cycle", 64'(initDoneCyc), 64'(PU + 3 * T + TC));
    checkOutput("ack_before_init", 64'(acks), 64'd0);
    checkOutput("init_pulse_count", 64'(pulses.size()), 64'd4);
    for (int k = 0; k < 4 && k < pulses.size(); k++)
      checkOutput($sformatf("init_cmd%0d", k),
                  64'({pulses[k].rs, pulses[k].data, pulses[k].cycle}),
                  64'({1'b0, expCmd[k], PU + S + k * T}));
  endtask

  // Requests one line and checks ack latency, byte contents/order/spacing and done latency.
  task automatic applyStimulus(input vec_t v, input bit holdReq, input bit pokeBusy);
    logic [7:0] expBytes[17];
    int start;
    int ackCyc = -1;
    int doneCyc = -1;
    int extraAcks = 0;
    expBytes[0] = v.expAddr;
    for (int c = 0; c < 16; c++) expBytes[c + 1] = v.data[127 - 8 * c -: 8];
    pulses.delete();
    req = 1'b1;
    line_sel = v.sel;
    line_data = v.data;
    start = cyc;
    for (int i = 0; i < 50 && ackCyc < 0; i++) begin
      tick();
      if (ack) begin
        ackCyc = cyc;
        checkOutput("busy_at_ack", 64'(busy), 64'd1);
        if (!holdReq) req = 1'b0;
        line_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        line_sel = ~v.sel;
      end
    end
    checkOutput("ack_latency", 64'(ackCyc), 64'(start + 1));
    if (ackCyc < 0) return;
    for (int i = 0; i < 400 && doneCyc < 0; i++) begin
      tick();
      if (pokeBusy && cyc == ackCyc + 20) req = 1'b1;
      if (pokeBusy && cyc == ackCyc + 21) req = 1'b0;
      if (ack) extraAcks++;
      if (done) begin
        doneCyc = cyc;
        checkOutput("busy_at_done", 64'(busy), 64'd0);
      end
    end
    checkOutput("done_latency", 64'(doneCyc), 64'(ackCyc + 17 * T));
    checkOutput("extra_ack", 64'(extraAcks), 64'd0);
    checkOutput("pulse_count", 64'(pulses.size()), 64'd17);
    for (int k = 0; k < 17 && k < pulses.size(); k++)
      checkOutput($sformatf("byte%0d", k),
                  64'({pulses[k].rs, pulses[k].data, pulses[k].cycle}),
                  64'({(k != 0), expBytes[k], ackCyc + S + k * T}));
  endtask

  initial begin
    logic [127:0] pusan;
    logic [127:0] dongnae;
    logic [127:0] rnd;
    int acks;
    int doneSeen;
    vec_t v;

    pusan   = "Pusan Nat'l Univ";
    dongnae = "Dongnae         ";
    vecs.push_back('{1'b0, pusan, 8'h80});
    vecs.push_back('{1'b1, dongnae, 8'hC0});
    for (int i = 0; i < 4; i++) begin
      v.sel     = 1'($urandom_range(0, 1));
      v.data    = {$urandom(), $urandom(), $urandom(), $urandom()};
      v.expAddr = 8'h80 + (v.sel ? 8'h40 : 8'h00);
      vecs.push_back(v);
    end

    // Reset held with req already high: nothing may be acknowledged until init completes.
    rst_n = 1'b0;
    req = 1'b1;
    line_sel = 1'b0;
    line_data = pusan;
    repeat (3) tick();
    checkResetOutputs("reset");
    initSequence();

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i], 1'b0, (i == 1));

    // req left high after done: the very next cycle carries a new ack.
    applyStimulus(vecs[2], 1'b1, 1'b0);
    tick();
    checkOutput("ack_after_done", 64'(ack), 64'd1);
    req = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 400 && doneSeen == 0; i++) begin
      tick();
      if (done) doneSeen = 1;
    end
    checkOutput("second_line_done", 64'(doneSeen), 64'd1);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack) acks++;
    end
    checkOutput("idle_no_ack", 64'(acks), 64'd0);

    // Reset while E is high on char 7 (ninth pulse of the line).
    rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
    pulses.delete();
    req = 1'b1;
    line_sel = 1'b0;
    line_data = rnd;
    acks = 0;
    for (int i = 0; i < 50 && acks == 0; i++) begin
      tick();
      if (ack) acks = 1;
    end
    req = 1'b0;
    for (int i = 0; i < 200 && pulses.size() < 9; i++) tick();
    checkOutput("char7_e_high", 64'(lcd_e), 64'd1);
    if (pulses.size() >= 9)
      checkOutput("char7_data", 64'(pulses[8].data), 64'(rnd[127 - 8 * 7 -: 8]));
    else
      checkOutput("char7_reached", 64'(pulses.size()), 64'd9);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_lcd_e", 64'(lcd_e), 64'd0);
    checkOutput("async_busy", 64'(busy), 64'd0);
    checkOutput("async_lcd_data", 64'(lcd_data), 64'd0);
    repeat (2) tick();
    checkResetOutputs("midline_reset");
    req = 1'b1;
    line_sel = 1'b1;
    line_data = pusan;
    initSequence();
    applyStimulus('{1'b1, pusan, 8'hC0}, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lcd_line_writer.md
# lcd_line_writer

Sequencer that drives a 16x2 HD44780-style character LCD in 8-bit write-only mode. It runs the power-up initialisation, then accepts 128-bit, 16-character ASCII lines from the station-name decoders through a request/acknowledge handshake. Each accepted line is written to LCD row 0 or row 1 with correct enable-pulse and command-wait timing. It sits between the location/name datapath and the LCD pins.

## Interface
Parameters:
- POWERUP_CYC, 750000: cycles to wait after reset before the first command (15 ms at 50 MHz).
- SETUP_CYC, 4: cycles RS/DATA are valid with E low before E rises.
- E_PULSE_CYC, 25: cycles E is held high.
- WAIT_CYC, 2500: cycles after E falls before the next byte (normal command/char).
- CLEAR_WAIT_CYC, 100000: cycles after E falls for the clear-display command.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  line write request; level, sampled only in IDLE.
- line_sel  in  1  0 = row 0 (DDRAM 0x00), 1 = row 1 (DDRAM 0x40).
- line_data  in  128  16 ASCII chars; [127:120] = column 0, [7:0] = column 15.
- ack  out  1  one-cycle pulse: request accepted, inputs latched.
- busy  out  1  high from ack through the last byte's wait.
- done  out  1  one-cycle pulse: line fully written.
- init_done  out  1  high once the init sequence has completed; stays high until reset.
- lcd_rs  out  1  0 = command, 1 = data.
- lcd_rw  out  1  constant 0 (write only).
- lcd_e  out  1  enable strobe.
- lcd_data  out  8  byte bus.

## Operation
- Top FSM: PWRUP -> INIT -> IDLE -> ADDR -> CHAR -> IDLE.
- PWRUP: count POWERUP_CYC, then go to INIT.
- INIT: write commands 0x38 (function set), 0x0C (display on, cursor off), 0x06 (entry increment), 0x01 (clear), in that order, all with RS = 0. Clear uses CLEAR_WAIT_CYC; the others use WAIT_CYC. After the clear completes, init_done rises and the FSM goes to IDLE.
- IDLE: if init_done and req are both high at a clock edge:
  - latch line_data and line_sel;
  - pulse ack for the next cycle;
  - raise busy;
  - go to ADDR.
- ADDR: write command 0x80 | (line_sel ? 0x40 : 0x00) with RS = 0.
- CHAR: write latched bytes with RS = 1, column 0 first, index 0..15. After index 15 completes, pulse done, drop busy, return to IDLE.
- Byte write, for every byte (3 phases, one shared down-counter):
  - SETUP: lcd_rs/lcd_data driven, E = 0, SETUP_CYC cycles.
  - PULSE: E = 1, E_PULSE_CYC cycles.
  - WAIT: E = 0, data held, WAIT_CYC or CLEAR_WAIT_CYC cycles.
- Each byte takes T = SETUP_CYC + E_PULSE_CYC + wait cycles. A line is 17 bytes.
- req while busy, or before init_done, is ignored. There is no queue. The requester must hold req until ack; a req still high after done starts a new write.
- line_data/line_sel changes after ack have no effect on the line in progress.
- Char index counter is 4 bits and does not wrap. Leaving CHAR is decided when index = 15 finishes its WAIT.

## Timing
- Reset values (asynchronous, immediate): ack = 0, busy = 0, done = 0, init_done = 0, lcd_rs = 0, lcd_rw = 0, lcd_e = 0, lcd_data = 0x00; FSM = PWRUP; all counters = 0.
- Reset mid-line or mid-init: outputs go to reset values at once. After release, the full PWRUP + INIT sequence repeats. No partial line is resumed.
- Accept edge = cycle 0. In cycle 1, ack = 1 and busy = 1, and the ADDR byte SETUP begins.
- done is high in cycle 1 + 17·T. busy falls in the same cycle. The earliest next accept edge is that cycle's closing edge.
- lcd_e is registered (glitch-free). lcd_data/lcd_rs never change while lcd_e = 1, or in the cycle E falls.
- First INIT command SETUP begins the cycle after PWRUP's count expires. init_done rises the cycle after the clear's CLEAR_WAIT ends.

## Structure
- Package lcd_pkg:
  - command constants LCD_FUNC_SET = 0x38, LCD_DISP_ON = 0x0C, LCD_ENTRY = 0x06, LCD_CLEAR = 0x01, LCD_DDRAM = 0x80, LCD_ROW1_OFS = 0x40;
  - top state enum;
  - byte-phase enum.
- Sub-module lcd_byte_writer: start/rs/data/long_wait inputs, done output; owns the phase counter and lcd_e. The top FSM sequences bytes through it.

## Test plan
Use SETUP = 2, PULSE = 3, WAIT = 4, CLEAR_WAIT = 10, POWERUP = 20, so T = 9, T_clear = 15.
- Release reset: E pulses carry 0x38, 0x0C, 0x06, 0x01 with RS = 0, in order. The first pulse begins after 20 + 2 cycles. init_done rises after the clear wait.
- req held before init_done: no ack until init_done. ack then arrives exactly 1 cycle after the first edge where both are high.
- req with line_sel = 0, data "Pusan Nat'l Univ": 0x80 with RS = 0, then 0x50, 0x75, … 0x76 with RS = 1. done arrives 153 cycles after ack.
- line_sel = 1, data "Dongnae" + 9 spaces: address byte 0x C0; trailing bytes 0x20. line_data is changed right after ack and is not reflected on lcd_data.
- Pulse req during busy, with req low before done: ignored, no second ack. req held high through done: a new ack follows immediately.
- Assert rst_n low at char 7 while E is high: lcd_e/busy drop asynchronously. After release, the INIT sequence repeats and no char bytes appear before init_done.
